// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the bit-counter width helper.
// uart_rx uses this package now, and uart_tx is expected to use it as well.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS = 8;

    // Width of a counter that runs 0..div-1.
    function automatic int div_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Receive FIFO with first-word fall-through output.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   push, din     : write din when not full; a pop in the same cycle frees a slot
//   pop           : remove the head entry; ignored when empty
//   dout          : head entry, 0 when empty
//   empty, full   : occupancy flags
//   count         : number of entries, 0..DEPTH
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // When full, a simultaneous pop frees the head slot, which is exactly
    // the slot wr_ptr points at, so the write lands there.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1) with a receive FIFO and sticky error flags.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   uart_rxd    : asynchronous serial input, idle high
//   rd          : pop FIFO head (ignored when empty)
//   clr         : clear overrun / frame_err (an error in the same cycle wins)
//   rx_data     : FIFO head, 0 when empty
//   rx_valid    : FIFO non-empty
//   rx_full     : FIFO holds FIFO_DEPTH entries
//   overrun     : sticky, a byte was dropped on a full FIFO
//   frame_err   : sticky, a stop bit was sampled low
//   irq         : rx_valid delayed by one cycle
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 5208,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    input  logic       rd,
    input  logic       clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_full,
    output logic       overrun,
    output logic       frame_err,
    output logic       irq
);

    localparam int BCNT_W = div_width(BAUD_DIV);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(BAUD_DIV - 1);
    localparam logic [BCNT_W-1:0] HALF_LAST = BCNT_W'(BAUD_DIV / 2 - 1);

    logic [1:0]           sync_q, sync_d;
    uart_state_e          state_q, state_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;
    logic                 irq_q, irq_d;

    logic             rxs;
    logic             push_req, ferr_evt, ovr_evt;
    logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CNT_W-1:0] fifo_count;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    assign sync_d = {sync_q[0], uart_rxd};
    assign rxs    = sync_q[1];

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        push_req = 1'b0;
        ferr_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bcnt_d = '0;
                if (!rxs) state_d = ST_START;
            end
            ST_START: begin
                // Mid-start-bit check; a high line here was only a glitch.
                if (bcnt_q == HALF_LAST) begin
                    bcnt_d  = '0;
                    idx_d   = '0;
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bcnt_q == BIT_LAST) begin
                    bcnt_d  = '0;
                    shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == 3'd7) state_d = ST_STOP;
                    else               idx_d   = idx_q + 1'b1;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bcnt_q == BIT_LAST) begin
                    bcnt_d   = '0;
                    state_d  = ST_IDLE;
                    push_req = rxs;
                    ferr_evt = ~rxs;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A read in the same cycle makes room, so a push onto a full FIFO is
    // only an overrun when no read accompanies it.
    assign fifo_pop  = rd & rx_valid;
    assign fifo_push = push_req & (~fifo_full | fifo_pop);
    assign ovr_evt   = push_req & fifo_full & ~fifo_pop;

    assign overrun_d   = (overrun_q & ~clr) | ovr_evt;
    assign frame_err_d = (frame_err_q & ~clr) | ferr_evt;
    assign irq_d       = rx_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= 2'b11;
            state_q     <= ST_IDLE;
            bcnt_q      <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_q       <= irq_d;
        end
    end

    rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (shreg_q),
        .dout  (rx_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign rx_valid  = ~fifo_empty;
    assign rx_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign irq       = irq_q;

endmodule
